ring_phase_monitor: RTL and testbench
=====================================

// Module: ring_phase_monitor
// PURPOSE
//  Receiving end of the 4-phase one-hot ring sequence O_0..O_3 (rotates 0001->0010->0100->1000->0001).
//  Samples the ring, decodes the active phase to an index and validates one-hot legality and rotation order.
//  Acquires and holds lock with a local flywheel, flags errors and counts full revolutions.
//  Sits on the same CLK as the ring generator and feeds status/debug outputs.
// PARAMETERS
//  LOCK_COUNT  4  consecutive good transitions in ACQ required to assert LOCKED (>=1)
//  ERR_LIMIT   2  consecutive bad samples in LOCKED that drop lock (>=1)
//  CNT_W       8  width of revolution counter REV_CNT
// PORTS
//  CLK      in   1      clock, rising edge
//  RST      in   1      reset, synchronous, active-high
//  PH_IN    in   4      ring phases, bit n = O_n
//  PHASE    out  2      index of the set bit of the last sample (0 if invalid)
//  VALID    out  1      last sample was exactly one-hot
//  LOCKED   out  1      FSM in LOCKED
//  ERR      out  1      1-cycle pulse: bad sample while LOCKED
//  REV_STB  out  1      1-cycle pulse: good sample of 0001 while LOCKED
//  REV_CNT  out  CNT_W  revolution count, wraps to 0 after all-ones
// BEHAVIOUR
//  - Stage 1: s_cur <= PH_IN every edge. All decisions use s_cur; all outputs registered at the next edge.
//    Total latency PH_IN -> outputs: 2 edges.
//  - onehot = exactly one bit of s_cur set; rotl(x) = {x[2:0],x[3]}.
//  - exp register (expected sample): in LOCKED exp <= rotl(exp) (flywheel); otherwise exp <= rotl(s_cur).
//  - good = onehot && (s_cur == exp); bad = !good.
//  - FSM (2-bit state), evaluated each cycle:
//    HUNT:   onehot -> ACQ, good_cnt<=0; else stay.
//    ACQ:    good && good_cnt==LOCK_COUNT-1 -> LOCKED, err_cnt<=0; good -> good_cnt++;
//            bad && onehot -> ACQ, good_cnt<=0 (restart); bad && !onehot -> HUNT.
//    LOCKED: good -> err_cnt<=0; bad -> ERR<=1, err_cnt++;
//            bad && err_cnt==ERR_LIMIT-1 -> HUNT (the ERR pulse still fires on this sample).
//  - Flywheel: an isolated glitch in LOCKED costs exactly one bad sample; the phase is not re-derived from the glitch.
//  - REV_STB/REV_CNT++ only when state==LOCKED && good && s_cur==4'b0001.
//    A bad sample never increments. REV_CNT is held across loss of lock and is cleared only by RST.
//  - PHASE/VALID: updated every cycle from s_cur irrespective of FSM state; invalid sample gives PHASE=0, VALID=0.
//  - RST (sync, any state, mid-revolution included): next edge gives
//    s_cur=0, exp=0, state=HUNT, good_cnt=0, err_cnt=0,
//    PHASE=0, VALID=0, LOCKED=0, ERR=0, REV_STB=0, REV_CNT=0.
//  - Counters good_cnt/err_cnt are sized for LOCK_COUNT/ERR_LIMIT and never wrap (bounded by the transitions above).
// TESTING
//  T1 lock: RST 1 cycle, then PH_IN rotates 0001,0010,0100,1000,... one per cycle
//     -> LOCKED=0 through edge 5, LOCKED=1 from edge 6 after RST release; VALID=1, PHASE follows 0,1,2,3 lagging 2 edges.
//  T2 revolutions: continue T1 -> REV_STB pulses at edges 10,14,18; REV_CNT=1,2,3.
//     With CNT_W=2, run 5 revolutions -> REV_CNT wraps 3->0.
//  T3 glitch: while LOCKED, replace one 0100 sample with 0110
//     -> one ERR pulse, VALID=0 and PHASE=0 for that cycle, LOCKED stays 1, REV_CNT still increments on the next 0001.
//  T4 stall: while LOCKED, hold PH_IN=0100 for 3 cycles (ERR_LIMIT=2)
//     -> ERR high 2 consecutive cycles, LOCKED falls at the 2nd;
//     after resuming rotation, LOCKED re-asserts after 1+LOCK_COUNT good samples.
//  T5 bad acquisition: PH_IN 0001,0010,1000,0001,... during ACQ
//     -> good_cnt restarts on 1000, LOCKED delayed accordingly;
//     PH_IN=0000 in ACQ -> back to HUNT; ERR never pulses outside LOCKED.
//  T6 mid-op reset: assert RST 1 cycle while LOCKED with REV_CNT=5
//     -> all outputs 0 next edge; relock per T1 timing.

Source files
------------

// File: rtl/ring_phase_monitor.sv
// Receiving end of a 4-phase one-hot ring. Samples the ring, decodes the active
// phase, checks one-hot legality and rotation order against a local flywheel,
// acquires/holds lock, flags errors while locked and counts full revolutions.
module ring_phase_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 2,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       PH_IN,
  output logic [1:0]       PHASE,
  output logic             VALID,
  output logic             LOCKED,
  output logic             ERR,
  output logic             REV_STB,
  output logic [CNT_W-1:0] REV_CNT
);

  // Counters only ever reach LOCK_COUNT-1 / ERR_LIMIT-1, so size them for that.
  localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int EW = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [3:0] x);
    case (x)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] phase_idx(input logic [3:0] x);
    case (x)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  logic [3:0]    s_cur_p0;
  logic [3:0]    exp_p0;
  state_t        state;
  logic [GW-1:0] good_cnt;
  logic [EW-1:0] err_cnt;
  logic          onehot_p0;
  logic          good_p0;

  // ---- stage 0: raw ring sample ----
  // Capture the ring once per edge; every decision below works from this copy.
  always_ff @(posedge CLK) begin
    if (RST) s_cur_p0 <= 4'b0000;
    else     s_cur_p0 <= PH_IN;
  end

  // Classify the held sample against the expected phase.
  always_comb begin
    onehot_p0 = is_onehot(s_cur_p0);
    good_p0   = onehot_p0 && (s_cur_p0 == exp_p0);
  end

  // ---- stage 1: registered decode and status ----
  // Phase index and legality track the sample regardless of lock state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PHASE <= 2'd0;
      VALID <= 1'b0;
    end else begin
      PHASE <= onehot_p0 ? phase_idx(s_cur_p0) : 2'd0;
      VALID <= onehot_p0;
    end
  end

  // Lock FSM with flywheel expectation, error/revolution pulses and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_HUNT;
      exp_p0   <= 4'b0000;
      good_cnt <= '0;
      err_cnt  <= '0;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
      REV_STB  <= 1'b0;
      REV_CNT  <= '0;
    end else begin
      ERR     <= 1'b0;
      REV_STB <= 1'b0;
      // Once locked the expectation free-runs, so a glitch cannot shift the phase.
      exp_p0  <= (state == ST_LOCKED) ? rotl(exp_p0) : rotl(s_cur_p0);
      case (state)
        ST_HUNT: begin
          if (onehot_p0) begin
            state    <= ST_ACQ;
            good_cnt <= '0;
          end
        end
        ST_ACQ: begin
          if (good_p0) begin
            if (good_cnt == GOOD_LAST) begin
              state   <= ST_LOCKED;
              err_cnt <= '0;
              LOCKED  <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end else if (onehot_p0) begin
            good_cnt <= '0;
          end else begin
            state <= ST_HUNT;
          end
        end
        ST_LOCKED: begin
          if (good_p0) begin
            err_cnt <= '0;
            if (s_cur_p0 == 4'b0001) begin
              REV_STB <= 1'b1;
              REV_CNT <= REV_CNT + 1'b1;
            end
          end else begin
            ERR <= 1'b1;
            if (err_cnt == ERR_LAST) begin
              state  <= ST_HUNT;
              LOCKED <= 1'b0;
            end else begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_HUNT;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench for ring_phase_monitor: directed vector table, hand-written
// corner sequences and randomized ring traffic against a behavioural model.
module tb_ring_phase_monitor;

  localparam int LOCK_COUNT = 4;
  localparam int ERR_LIMIT  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ph;

  logic [1:0] phase8, phase2;
  logic       valid8, valid2, locked8, locked2, err8, err2, stb8, stb2;
  logic [7:0] rev8;
  logic [1:0] rev2;

  always #5 clk = ~clk;

  ring_phase_monitor #(.LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(8)) dut8 (
    .CLK(clk), .RST(rst), .PH_IN(ph), .PHASE(phase8), .VALID(valid8),
    .LOCKED(locked8), .ERR(err8), .REV_STB(stb8), .REV_CNT(rev8));

  ring_phase_monitor #(.LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(2)) dut2 (
    .CLK(clk), .RST(rst), .PH_IN(ph), .PHASE(phase2), .VALID(valid2),
    .LOCKED(locked2), .ERR(err2), .REV_STB(stb2), .REV_CNT(rev2));

  int checks   = 0;
  int failures = 0;
  int ring_idx = 0;

  // Behavioural model: phases as indices 0..3 (-1 = not a legal one-hot sample).
  int         m_mode = 0;   // 0 hunt, 1 acquire, 2 locked
  int         m_good = 0;
  int         m_bad  = 0;
  int         m_sidx = -1;
  int         m_exp  = -1;
  int         m_rev  = 0;
  logic [1:0] m_phase = 2'd0;
  logic       m_valid = 1'b0, m_locked = 1'b0, m_err = 1'b0, m_stb = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] ph;
    logic [1:0] phase;
    logic       valid;
    logic       locked;
    logic       stb;
    logic [7:0] rev;
  } vec_t;

  vec_t tv[19];

  function automatic vec_t mkv(input logic r, input logic [3:0] p, input logic [1:0] po,
                               input logic v, input logic l, input logic s, input logic [7:0] rv);
    vec_t t;
    t.rst = r; t.ph = p; t.phase = po; t.valid = v; t.locked = l; t.stb = s; t.rev = rv;
    return t;
  endfunction

  function automatic int idx_of(input logic [3:0] x);
    int r;
    r = -1;
    if ($countones(x) == 1)
      for (int i = 0; i < 4; i++) if (x[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] p);
    int cur;
    logic oh, gd;
    if (r) begin
      m_mode = 0; m_good = 0; m_bad = 0; m_exp = -1; m_rev = 0;
      m_phase = 2'd0; m_valid = 1'b0; m_locked = 1'b0; m_err = 1'b0; m_stb = 1'b0;
      m_sidx = -1;
    end else begin
      cur = m_sidx;
      oh  = (cur >= 0);
      gd  = oh && (cur == m_exp);
      m_phase = oh ? 2'(cur) : 2'd0;
      m_valid = oh;
      m_err   = (m_mode == 2) && !gd;
      m_stb   = (m_mode == 2) && gd && (cur == 0);
      if (m_stb) m_rev++;
      if (m_mode == 2) m_exp = (m_exp + 1) % 4;
      else             m_exp = oh ? (cur + 1) % 4 : -1;
      case (m_mode)
        0: if (oh) begin m_mode = 1; m_good = 0; end
        1: begin
          if (gd) begin
            if (m_good == LOCK_COUNT - 1) begin m_mode = 2; m_bad = 0; end
            else m_good++;
          end else if (oh) m_good = 0;
          else m_mode = 0;
        end
        default: begin
          if (gd) m_bad = 0;
          else if (m_bad == ERR_LIMIT - 1) m_mode = 0;
          else m_bad++;
        end
      endcase
      m_locked = (m_mode == 2);
      m_sidx = idx_of(p);
    end
  endtask

  // Apply one input set across one clock edge, then compare both DUTs to the model.
  task automatic step(input logic r, input logic [3:0] p);
    rst = r;
    ph  = p;
    @(posedge clk);
    model_edge(r, p);
    #1;
    check("model_w8", 32'({phase8, valid8, locked8, err8, stb8, rev8}),
          32'({m_phase, m_valid, m_locked, m_err, m_stb, 8'(m_rev)}));
    check("model_w2", 32'({phase2, valid2, locked2, err2, stb2, rev2}),
          32'({m_phase, m_valid, m_locked, m_err, m_stb, 2'(m_rev)}));
  endtask

  task automatic ring(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 4'(1 << ring_idx));
      ring_idx = (ring_idx + 1) % 4;
    end
  endtask

  initial begin
    int errsum, lowsum, rb, k;
    logic [3:0] p, seq5[8], seq5b[9];
    logic r;

    rst = 1'b1;
    ph  = 4'b0000;

    // T1/T2: lock timing, phase lag and revolution strobes after reset.
    tv[0]  = mkv(1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[1]  = mkv(1'b0, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tv[2]  = mkv(1'b0, 4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    tv[3]  = mkv(1'b0, 4'b0100, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0);
    tv[4]  = mkv(1'b0, 4'b1000, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0);
    tv[5]  = mkv(1'b0, 4'b0001, 2'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    tv[6]  = mkv(1'b0, 4'b0010, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    tv[7]  = mkv(1'b0, 4'b0100, 2'd1, 1'b1, 1'b1, 1'b0, 8'd0);
    tv[8]  = mkv(1'b0, 4'b1000, 2'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    tv[9]  = mkv(1'b0, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
    tv[10] = mkv(1'b0, 4'b0010, 2'd0, 1'b1, 1'b1, 1'b1, 8'd1);
    tv[11] = mkv(1'b0, 4'b0100, 2'd1, 1'b1, 1'b1, 1'b0, 8'd1);
    tv[12] = mkv(1'b0, 4'b1000, 2'd2, 1'b1, 1'b1, 1'b0, 8'd1);
    tv[13] = mkv(1'b0, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b0, 8'd1);
    tv[14] = mkv(1'b0, 4'b0010, 2'd0, 1'b1, 1'b1, 1'b1, 8'd2);
    tv[15] = mkv(1'b0, 4'b0100, 2'd1, 1'b1, 1'b1, 1'b0, 8'd2);
    tv[16] = mkv(1'b0, 4'b1000, 2'd2, 1'b1, 1'b1, 1'b0, 8'd2);
    tv[17] = mkv(1'b0, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b0, 8'd2);
    tv[18] = mkv(1'b0, 4'b0010, 2'd0, 1'b1, 1'b1, 1'b1, 8'd3);

    for (int i = 0; i < 19; i++) begin
      step(tv[i].rst, tv[i].ph);
      check($sformatf("tv%0d_out", i), 32'({phase8, valid8, locked8, err8, stb8, rev8}),
            32'({tv[i].phase, tv[i].valid, tv[i].locked, 1'b0, tv[i].stb, tv[i].rev}));
      check($sformatf("tv%0d_rev2", i), 32'(rev2), 32'(tv[i].rev[1:0]));
    end

    // T2 wrap: narrow counter wraps 3->0 on the 4th revolution.
    ring_idx = 2;
    ring(4);
    check("wrap_rev8_4", 32'(rev8), 32'd4);
    check("wrap_rev2_0", 32'(rev2), 32'd0);
    ring(4);
    check("rev8_5", 32'(rev8), 32'd5);
    check("rev2_1", 32'(rev2), 32'd1);
    check("locked_pre_rst", 32'(locked8), 32'd1);

    // T6: mid-operation reset clears everything, relock follows T1 timing.
    step(1'b1, 4'(1 << ring_idx));
    check("rst_all8", 32'({phase8, valid8, locked8, err8, stb8, rev8}), 32'd0);
    check("rst_all2", 32'({phase2, valid2, locked2, err2, stb2, rev2}), 32'd0);
    ring_idx = 0;
    ring(5);
    check("relock_e5", 32'(locked8), 32'd0);
    ring(1);
    check("relock_e6", 32'(locked8), 32'd1);

    // T3: single glitch replaces a 0100 sample.
    while (ring_idx != 2) ring(1);
    rb = m_rev;
    errsum = 0; lowsum = 0;
    step(1'b0, 4'b0110);
    ring_idx = 3;
    errsum += int'(err8); lowsum += int'(!locked8);
    ring(1);
    check("glitch_err", 32'(err8), 32'd1);
    check("glitch_valid_phase", 32'({valid8, phase8}), 32'd0);
    errsum += int'(err8); lowsum += int'(!locked8);
    for (int i = 0; i < 7; i++) begin
      ring(1);
      errsum += int'(err8); lowsum += int'(!locked8);
    end
    check("glitch_one_err", 32'(errsum), 32'd1);
    check("glitch_lock_held", 32'(lowsum), 32'd0);
    check("glitch_rev_inc", 32'(rev8), 32'(8'(rb + 2)));

    // T4: stall on 0100 for three cycles drops lock after two errors.
    while (ring_idx != 2) ring(1);
    step(1'b0, 4'b0100);
    check("stall_a", 32'({err8, locked8}), 32'b01);
    step(1'b0, 4'b0100);
    check("stall_b", 32'({err8, locked8}), 32'b01);
    step(1'b0, 4'b0100);
    check("stall_c", 32'({err8, locked8}), 32'b11);
    ring_idx = 3;
    ring(1);
    check("stall_d", 32'({err8, locked8}), 32'b10);
    ring(4);
    check("stall_relock_pre", 32'(locked8), 32'd0);
    ring(1);
    check("stall_relock", 32'(locked8), 32'd1);

    // T5: out-of-order sample during acquisition restarts the good count.
    seq5 = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step(1'b1, 4'b0000);
    errsum = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, seq5[i]);
      errsum += int'(err8);
      if (i == 6) check("acq_restart_e7", 32'(locked8), 32'd0);
    end
    check("acq_restart_e8", 32'(locked8), 32'd1);
    check("acq_restart_noerr", 32'(errsum), 32'd0);

    // T5: an empty sample during acquisition returns to hunting.
    seq5b = '{4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    step(1'b1, 4'b0000);
    errsum = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, seq5b[i]);
      errsum += int'(err8);
      if (i == 7) check("acq_hunt_e8", 32'(locked8), 32'd0);
    end
    check("acq_hunt_e9", 32'(locked8), 32'd1);
    check("acq_hunt_noerr", 32'(errsum), 32'd0);
    ring_idx = 3;

    // Randomized ring traffic: mostly clean rotation with stalls, skips, junk and resets.
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      k = $urandom_range(0, 99);
      if (k < 85) begin
        p = 4'(1 << ring_idx);
        ring_idx = (ring_idx + 1) % 4;
      end else if (k < 91) begin
        p = 4'(1 << ((ring_idx + 3) % 4));
      end else if (k < 96) begin
        p = 4'($urandom);
      end else begin
        ring_idx = (ring_idx + 1) % 4;
        p = 4'(1 << ring_idx);
        ring_idx = (ring_idx + 1) % 4;
      end
      step(r, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
